mem_arbiter: RTL and testbench

- Arbitrates a single shared main-memory port between the I-cache and D-cache fill/write-through traffic.
- Sequences 8-word block fills by issuing word addresses on consecutive cycles and counting returned words.
- Issues single-word write-throughs.
- Sits between the two cache controllers and the multi-cycle memory model. Each cache sees a dedicated grant/valid/done handshake.

---
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between I-cache block fills and D-cache block
// fills / single-word write-throughs, with round-robin arbitration on contention.
module mem_arbiter #(
    parameter int MEM_LATENCY     = 4,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_data_valid,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic        i_grant,
    output logic        d_grant,
    output logic [15:0] fill_data,
    output logic        fill_valid_i,
    output logic        fill_valid_d,
    output logic [2:0]  fill_word,
    output logic        i_done,
    output logic        d_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_I_FILL  = 3'd1,
        S_D_FILL  = 3'd2,
        S_D_WRITE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic       OWN_I       = 1'b0;
    localparam logic       OWN_D       = 1'b1;
    localparam logic [3:0] BLOCK_WORDS = 4'(WORDS_PER_BLOCK);
    localparam logic [3:0] LAST_WORD   = 4'(WORDS_PER_BLOCK - 1);

    state_t      state_q, state_d;
    logic [3:0]  issue_cnt_q, issue_cnt_d;
    logic [3:0]  recv_cnt_q, recv_cnt_d;
    logic        last_owner_q, last_owner_d;
    logic        i_grant_q, i_grant_d;
    logic        d_grant_q, d_grant_d;
    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;
    logic        busy_q, busy_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;

    logic        pick_d;
    logic        fill_active;
    logic        issuing;

    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        last_owner_d = last_owner_q;
        i_grant_d    = i_grant_q;
        d_grant_d    = d_grant_q;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;
        busy_d       = busy_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        // D wins when alone, or on contention when I owned the port last.
        pick_d       = d_req && (!i_req || last_owner_q == OWN_I);

        case (state_q)
            S_IDLE: begin
                if (pick_d) begin
                    last_owner_d = OWN_D;
                    d_grant_d    = 1'b1;
                    busy_d       = 1'b1;
                    addr_d       = d_addr;
                    wdata_d      = d_wdata;
                    state_d      = d_write ? S_D_WRITE : S_D_FILL;
                end else if (i_req) begin
                    last_owner_d = OWN_I;
                    i_grant_d    = 1'b1;
                    busy_d       = 1'b1;
                    addr_d       = i_addr;
                    state_d      = S_I_FILL;
                end
            end
            S_I_FILL, S_D_FILL: begin
                if (issue_cnt_q != BLOCK_WORDS) begin
                    issue_cnt_d = issue_cnt_q + 4'd1;
                end
                if (mem_data_valid) begin
                    recv_cnt_d = recv_cnt_q + 4'd1;
                    if (recv_cnt_q == LAST_WORD) begin
                        state_d  = S_DONE;
                        i_done_d = (state_q == S_I_FILL);
                        d_done_d = (state_q == S_D_FILL);
                    end
                end
            end
            S_D_WRITE: begin
                state_d  = S_DONE;
                d_done_d = 1'b1;
            end
            S_DONE: begin
                state_d     = S_IDLE;
                i_grant_d   = 1'b0;
                d_grant_d   = 1'b0;
                busy_d      = 1'b0;
                issue_cnt_d = 4'd0;
                recv_cnt_d  = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            issue_cnt_q  <= 4'd0;
            recv_cnt_q   <= 4'd0;
            last_owner_q <= OWN_I;
            i_grant_q    <= 1'b0;
            d_grant_q    <= 1'b0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            recv_cnt_q   <= recv_cnt_d;
            last_owner_q <= last_owner_d;
            i_grant_q    <= i_grant_d;
            d_grant_q    <= d_grant_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            busy_q       <= busy_d;
        end
    end

    // Captured request address/data; only observed while the state says they are valid.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign fill_active = (state_q == S_I_FILL) || (state_q == S_D_FILL);
    assign issuing     = fill_active && (issue_cnt_q < BLOCK_WORDS);

    assign mem_enable = issuing || (state_q == S_D_WRITE);
    assign mem_wr     = (state_q == S_D_WRITE);
    assign mem_wdata  = mem_wr ? wdata_q : 16'h0000;

    always_comb begin
        mem_addr = 16'h0000;
        if (mem_wr) begin
            mem_addr = addr_q;
        end else if (issuing) begin
            mem_addr = {addr_q[15:4], issue_cnt_q[2:0], 1'b0};
        end
    end

    assign fill_valid_i = mem_data_valid && (state_q == S_I_FILL);
    assign fill_valid_d = mem_data_valid && (state_q == S_D_FILL);
    assign fill_data    = (fill_valid_i || fill_valid_d) ? mem_rdata : 16'h0000;
    assign fill_word    = recv_cnt_q[2:0];

    assign i_grant = i_grant_q;
    assign d_grant = d_grant_q;
    assign i_done  = i_done_q;
    assign d_done  = d_done_q;
    assign busy    = busy_q;

    // A returned word must line up with a read issued MEM_LATENCY cycles earlier.
    a_fill_latency : assert property (@(posedge clk) disable iff (rst)
        (fill_active && mem_data_valid) |-> $past(issuing, MEM_LATENCY));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table for write-through / stray valids,
// hand sequences with a fixed-latency memory model for fills, contention and reset.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_write;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] mem_rdata;
    logic        mem_data_valid;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_enable;
    logic        mem_wr;
    logic        i_grant;
    logic        d_grant;
    logic [15:0] fill_data;
    logic        fill_valid_i;
    logic        fill_valid_d;
    logic [2:0]  fill_word;
    logic        i_done;
    logic        d_done;
    logic        busy;

    mem_arbiter #(.MEM_LATENCY(4), .WORDS_PER_BLOCK(8)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_enable(mem_enable), .mem_wr(mem_wr),
        .i_grant(i_grant), .d_grant(d_grant),
        .fill_data(fill_data), .fill_valid_i(fill_valid_i), .fill_valid_d(fill_valid_d),
        .fill_word(fill_word), .i_done(i_done), .d_done(d_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Memory model: a read seen in cycle c returns addr^A5A5 in cycle c+4.
    logic        model_on;
    logic        pv [4];
    logic [15:0] pa [4];

    typedef struct {
        logic        d_req, d_write, mdv;
        logic [15:0] d_addr, d_wdata, rdata;
        logic        e_en, e_wr, e_grant, e_done, e_fv, e_busy;
        logic [15:0] e_addr, e_wdata;
    } vec_t;

    vec_t tbl [6];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clear_model();
        for (int s = 0; s < 4; s++) begin
            pv[s] = 1'b0;
            pa[s] = 16'h0;
        end
    endtask

    task automatic tick();
        if (model_on) begin
            for (int s = 3; s > 0; s--) begin
                pv[s] = pv[s-1];
                pa[s] = pa[s-1];
            end
            pv[0] = mem_enable && !mem_wr;
            pa[0] = mem_addr;
        end
        @(posedge clk);
        #1;
        if (model_on) begin
            mem_data_valid = pv[3];
            mem_rdata      = pv[3] ? (pa[3] ^ 16'hA5A5) : 16'h0000;
        end
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk16({tag, "_mem_addr"}, mem_addr, 16'h0);
        chk16({tag, "_mem_wdata"}, mem_wdata, 16'h0);
        chk1({tag, "_mem_enable"}, mem_enable, 1'b0);
        chk1({tag, "_mem_wr"}, mem_wr, 1'b0);
        chk1({tag, "_i_grant"}, i_grant, 1'b0);
        chk1({tag, "_d_grant"}, d_grant, 1'b0);
        chk16({tag, "_fill_data"}, fill_data, 16'h0);
        chk1({tag, "_fill_valid_i"}, fill_valid_i, 1'b0);
        chk1({tag, "_fill_valid_d"}, fill_valid_d, 1'b0);
        chk16({tag, "_fill_word"}, {13'b0, fill_word}, 16'h0);
        chk1({tag, "_i_done"}, i_done, 1'b0);
        chk1({tag, "_d_done"}, d_done, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
    endtask

    // Follows one fill until its done pulse, checking every returned word.
    task automatic run_fill(input logic is_i, input logic [15:0] base,
                            output int words, output logic seen_done);
        words = 0;
        seen_done = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (is_i ? fill_valid_i : fill_valid_d) begin
                chk16($sformatf("%s_word%0d", is_i ? "i" : "d", words),
                      {13'b0, fill_word}, 16'(words));
                chk16($sformatf("%s_data%0d", is_i ? "i" : "d", words),
                      fill_data, (base + 16'(2 * words)) ^ 16'hA5A5);
                words++;
            end
            if (is_i ? i_done : d_done) begin
                seen_done = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          words;
        logic        seen;
        logic        leak;
        logic        prev_i, prev_d;
        int          ng;
        int          order [4];
        logic [15:0] exp_addr;

        rst = 1'b1; i_req = 1'b0; i_addr = 16'h0; d_req = 1'b0; d_write = 1'b0;
        d_addr = 16'h0; d_wdata = 16'h0; mem_rdata = 16'h0; mem_data_valid = 1'b0;
        model_on = 1'b0;
        clear_model();

        tbl[0] = '{1'b1, 1'b1, 1'b1, 16'h4002, 16'hBEEF, 16'h1234,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 16'h4002, 16'hBEEF, 16'h5678,
                   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4002, 16'hBEEF};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 16'h4002, 16'hBEEF, 16'h9ABC,
                   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h1234,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};

        // Reset state, with a stray valid present
        tick();
        tick();
        mem_data_valid = 1'b1;
        mem_rdata = 16'h1111;
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        mem_data_valid = 1'b0;
        mem_rdata = 16'h0;
        tick();

        // I fill alone
        i_req = 1'b1;
        i_addr = 16'h1236;
        clear_model();
        model_on = 1'b1;
        tick();
        for (int k = 0; k < 14; k++) begin
            if (k == 2) i_addr = 16'hFFFF;
            if (k == 12) i_req = 1'b0;
            #1;
            chk1($sformatf("ifill_en_k%0d", k), mem_enable, k < 8);
            chk1($sformatf("ifill_wr_k%0d", k), mem_wr, 1'b0);
            if (k < 8) chk16($sformatf("ifill_addr_k%0d", k), mem_addr, 16'h1230 + 16'(2 * k));
            chk1($sformatf("ifill_fv_k%0d", k), fill_valid_i, (k >= 4) && (k <= 11));
            if ((k >= 4) && (k <= 11)) begin
                chk16($sformatf("ifill_word_k%0d", k), {13'b0, fill_word}, 16'(k - 4));
                chk16($sformatf("ifill_data_k%0d", k), fill_data,
                      (16'h1230 + 16'(2 * (k - 4))) ^ 16'hA5A5);
            end
            chk1($sformatf("ifill_fvd_k%0d", k), fill_valid_d, 1'b0);
            chk1($sformatf("ifill_grant_k%0d", k), i_grant, k <= 12);
            chk1($sformatf("ifill_done_k%0d", k), i_done, k == 12);
            chk1($sformatf("ifill_busy_k%0d", k), busy, k <= 12);
            tick();
        end

        // D write-through and stray valids
        model_on = 1'b0;
        clear_model();
        for (int v = 0; v < 6; v++) begin
            d_req = tbl[v].d_req;
            d_write = tbl[v].d_write;
            d_addr = tbl[v].d_addr;
            d_wdata = tbl[v].d_wdata;
            mem_data_valid = tbl[v].mdv;
            mem_rdata = tbl[v].rdata;
            #1;
            chk1($sformatf("wt%0d_en", v), mem_enable, tbl[v].e_en);
            chk1($sformatf("wt%0d_wr", v), mem_wr, tbl[v].e_wr);
            chk16($sformatf("wt%0d_addr", v), mem_addr, tbl[v].e_addr);
            chk16($sformatf("wt%0d_wdata", v), mem_wdata, tbl[v].e_wdata);
            chk1($sformatf("wt%0d_grant", v), d_grant, tbl[v].e_grant);
            chk1($sformatf("wt%0d_done", v), d_done, tbl[v].e_done);
            chk1($sformatf("wt%0d_fvd", v), fill_valid_d, tbl[v].e_fv);
            chk1($sformatf("wt%0d_fvi", v), fill_valid_i, tbl[v].e_fv);
            chk1($sformatf("wt%0d_busy", v), busy, tbl[v].e_busy);
            tick();
        end

        // Contention right after reset: D first, one idle cycle, then I
        rst = 1'b1;
        mem_data_valid = 1'b0;
        tick();
        rst = 1'b0;
        i_req = 1'b1; i_addr = 16'h2000;
        d_req = 1'b1; d_write = 1'b0; d_addr = 16'h3458;
        clear_model();
        model_on = 1'b1;
        tick();
        chk1("cont_d_grant", d_grant, 1'b1);
        chk1("cont_i_grant", i_grant, 1'b0);
        chk16("cont_d_addr0", mem_addr, 16'h3450);
        run_fill(1'b0, 16'h3450, words, seen);
        chk1("cont_d_done_seen", seen, 1'b1);
        chk16("cont_d_words", 16'(words), 16'd8);
        chk1("cont_i_grant_in_done", i_grant, 1'b0);
        d_req = 1'b0;
        tick();
        chk1("cont_gap_busy", busy, 1'b0);
        chk1("cont_gap_i_grant", i_grant, 1'b0);
        chk1("cont_gap_d_grant", d_grant, 1'b0);
        tick();
        chk1("cont_i_grant", i_grant, 1'b1);
        chk16("cont_i_addr0", mem_addr, 16'h2000);
        run_fill(1'b1, 16'h2000, words, seen);
        chk1("cont_i_done_seen", seen, 1'b1);
        chk16("cont_i_words", 16'(words), 16'd8);
        i_req = 1'b0;
        tick();

        // Round-robin with both requests held, D doing write-throughs
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_req = 1'b1; i_addr = 16'h6000;
        d_req = 1'b1; d_write = 1'b1; d_addr = 16'h5554; d_wdata = 16'hCAFE;
        clear_model();
        model_on = 1'b1;
        prev_i = 1'b0; prev_d = 1'b0; ng = 0; leak = 1'b0;
        for (int k = 0; k < 4; k++) order[k] = -1;
        for (int n = 0; n < 100 && ng < 4; n++) begin
            if (d_grant && !prev_d && ng < 4) begin order[ng] = 1; ng++; end
            if (i_grant && !prev_i && ng < 4) begin order[ng] = 0; ng++; end
            if (mem_wr) begin
                chk16("rr_waddr", mem_addr, 16'h5554);
                chk16("rr_wdata", mem_wdata, 16'hCAFE);
            end
            if (i_grant && d_grant) leak = 1'b1;
            prev_i = i_grant;
            prev_d = d_grant;
            if (ng < 4) tick();
        end
        chk16("rr_grants_seen", 16'(ng), 16'd4);
        chk1("rr_no_double_grant", leak, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk16($sformatf("rr_order%0d", k), 16'(order[k]), (k % 2 == 0) ? 16'd1 : 16'd0);
        end

        // Reset in the middle of an I fill
        rst = 1'b1;
        model_on = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_write = 1'b0;
        mem_data_valid = 1'b0;
        tick();
        rst = 1'b0;
        i_req = 1'b1;
        i_addr = 16'h7ABC;
        clear_model();
        model_on = 1'b1;
        tick();
        words = 0;
        for (int n = 0; n < 20; n++) begin
            if (fill_valid_i) words++;
            if (words == 3) break;
            tick();
        end
        chk16("rstmid_words_before", 16'(words), 16'd3);
        chk1("rstmid_busy_before", busy, 1'b1);
        model_on = 1'b0;
        tick();
        mem_data_valid = 1'b0;
        rst = 1'b1;
        i_req = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check_all_zero("rstmid");
        for (int k = 0; k < 5; k++) begin
            mem_data_valid = 1'b1;
            mem_rdata = 16'hDEAD;
            #1;
            chk1($sformatf("trail%0d_fvi", k), fill_valid_i, 1'b0);
            chk1($sformatf("trail%0d_fvd", k), fill_valid_d, 1'b0);
            chk1($sformatf("trail%0d_idone", k), i_done, 1'b0);
            chk1($sformatf("trail%0d_busy", k), busy, 1'b0);
            chk16($sformatf("trail%0d_fdata", k), fill_data, 16'h0);
            tick();
        end
        mem_data_valid = 1'b0;
        exp_addr = 16'h0;
        #1;
        chk16("final_mem_addr", mem_addr, exp_addr);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
